branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit_if.sv | 43 ++++
 rtl/branch_resolve_unit.sv | 182 ++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Fetch/EX/update bus of the branch resolve unit: prediction records in,
// resolutions in, predictor/BTB update and pipeline redirect out.
interface branch_resolve_unit_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  push_valid;
  logic                  push_ready;
  logic [DATA_WIDTH-1:0] push_pc;
  logic [DATA_WIDTH-1:0] push_target;
  logic                  push_hit;
  logic                  push_pred;

  logic                  resolve_valid;
  logic                  resolve_is_branch;
  logic                  resolve_is_jump;
  logic                  resolve_taken;
  logic [DATA_WIDTH-1:0] resolve_target;

  logic                  update_predictor;
  logic                  update_btb;
  logic                  actually_taken;
  logic [DATA_WIDTH-1:0] resolved_pc;
  logic [DATA_WIDTH-1:0] resolved_pc_target;
  logic                  flush;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  underflow_err;

  modport master (
    output push_valid, push_pc, push_target, push_hit, push_pred,
    output resolve_valid, resolve_is_branch, resolve_is_jump, resolve_taken, resolve_target,
    input  push_ready,
    input  update_predictor, update_btb, actually_taken, resolved_pc, resolved_pc_target,
    input  flush, redirect_pc, underflow_err
  );

  modport slave (
    input  push_valid, push_pc, push_target, push_hit, push_pred,
    input  resolve_valid, resolve_is_branch, resolve_is_jump, resolve_taken, resolve_target,
    output push_ready,
    output update_predictor, update_btb, actually_taken, resolved_pc, resolved_pc_target,
    output flush, redirect_pc, underflow_err
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: FIFO of fetch-time predictions checked against EX outcomes.
// Optional BR_RESOLVE_STATS_EN adds branch_count / mispredict_count outputs.
//
// state    | meaning
// ST_RUN   | accepting records and resolves
// ST_RECOVER | one cycle after a flush; pushes refused, resolves ignored
module branch_resolve_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  branch_resolve_unit_if.slave    bus
`ifdef BR_RESOLVE_STATS_EN
  ,
  output logic [31:0]             branch_count,
  output logic [31:0]             mispredict_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_RECOVER = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;

  logic [DATA_WIDTH-1:0] pc_mem_q  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] tgt_mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] hit_mem_q;
  logic [FIFO_DEPTH-1:0] pred_mem_q;

  logic                  upd_pred_q;
  logic                  upd_btb_q;
  logic                  taken_q;
  logic [DATA_WIDTH-1:0] rpc_q;
  logic [DATA_WIDTH-1:0] rtgt_q;
  logic                  flush_q;
  logic [DATA_WIDTH-1:0] redirect_q;
  logic                  uf_q;

  logic                  run;
  logic                  empty;
  logic                  full;
  logic                  push_ready;
  logic                  push_acc;
  logic                  resolve_acc;
  logic                  underflow_evt;
  logic                  is_ctrl;
  logic                  eff_taken;
  logic                  mispredict;
  logic [DATA_WIDTH-1:0] head_pc;
  logic [DATA_WIDTH-1:0] head_tgt;

  always_comb begin
    run           = (state_q == ST_RUN);
    empty         = (count_q == '0);
    full          = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    push_ready    = run & (~full | bus.resolve_valid);
    resolve_acc   = run & bus.resolve_valid & ~empty;
    underflow_evt = run & bus.resolve_valid & empty;

    head_pc   = pc_mem_q[rd_ptr_q];
    head_tgt  = tgt_mem_q[rd_ptr_q];
    eff_taken = hit_mem_q[rd_ptr_q] & pred_mem_q[rd_ptr_q];
    is_ctrl   = bus.resolve_is_branch | bus.resolve_is_jump;

    mispredict = resolve_acc & is_ctrl &
                 ((bus.resolve_taken != eff_taken) |
                  (bus.resolve_taken & eff_taken & (bus.resolve_target != head_tgt)));

    // A flushing resolve wipes the FIFO, so a push in the same cycle is lost.
    push_acc = bus.push_valid & push_ready & ~mispredict;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (mispredict) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_acc)
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (resolve_acc)
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_acc, resolve_acc})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    state_d = ST_RUN;
    case (state_q)
      ST_RUN:     state_d = mispredict ? ST_RECOVER : ST_RUN;
      ST_RECOVER: state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      pc_mem_q[wr_ptr_q]   <= bus.push_pc;
      tgt_mem_q[wr_ptr_q]  <= bus.push_target;
      hit_mem_q[wr_ptr_q]  <= bus.push_hit;
      pred_mem_q[wr_ptr_q] <= bus.push_pred;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      upd_pred_q <= 1'b0;
      upd_btb_q  <= 1'b0;
      taken_q    <= 1'b0;
      rpc_q      <= '0;
      rtgt_q     <= '0;
      flush_q    <= 1'b0;
      redirect_q <= '0;
      uf_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      upd_pred_q <= resolve_acc & bus.resolve_is_branch;
      upd_btb_q  <= resolve_acc & bus.resolve_taken & is_ctrl;
      flush_q    <= mispredict;
      if (resolve_acc & is_ctrl) begin
        taken_q <= bus.resolve_taken;
        rpc_q   <= head_pc;
        rtgt_q  <= bus.resolve_target;
      end
      if (mispredict)
        redirect_q <= bus.resolve_taken ? bus.resolve_target : head_pc + DATA_WIDTH'(4);
      if (underflow_evt)
        uf_q <= 1'b1;
    end
  end

`ifdef BR_RESOLVE_STATS_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] mispredict_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (resolve_acc & is_ctrl)
        branch_cnt_q <= branch_cnt_q + 32'd1;
      if (mispredict)
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end
  end

  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mispredict_cnt_q;
`endif

  assign bus.push_ready         = push_ready;
  assign bus.update_predictor   = upd_pred_q;
  assign bus.update_btb         = upd_btb_q;
  assign bus.actually_taken     = taken_q;
  assign bus.resolved_pc        = rpc_q;
  assign bus.resolved_pc_target = rtgt_q;
  assign bus.flush              = flush_q;
  assign bus.redirect_pc        = redirect_q;
  assign bus.underflow_err      = uf_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed + random bench for branch_resolve_unit; a behavioural model queues the
// expected registered outputs each cycle and they are checked after the edge.
module tb_branch_resolve_unit;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [DW-1:0] pc;
    logic [DW-1:0] tgt;
    logic          hit;
    logic          pred;
  } rec_t;

  typedef struct {
    logic          up;
    logic          ub;
    logic          at;
    logic [DW-1:0] rpc;
    logic [DW-1:0] rtgt;
    logic          fl;
    logic [DW-1:0] rd;
    logic          uf;
    logic [31:0]   bc;
    logic [31:0]   mc;
  } exp_t;

  logic clk;
  logic rstn;
  int   vectors;
  int   miscompares;

  rec_t mq[$];
  exp_t sb[$];
  logic          m_state;
  logic          m_at;
  logic [DW-1:0] m_rpc;
  logic [DW-1:0] m_rtgt;
  logic [DW-1:0] m_rd;
  logic          m_uf;
  logic [31:0]   m_bc;
  logic [31:0]   m_mc;

  branch_resolve_unit_if #(.DATA_WIDTH(DW)) bus ();

`ifdef BR_RESOLVE_STATS_EN
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;
  branch_resolve_unit #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );
`else
  branch_resolve_unit #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.push_valid        = 1'b0;
    bus.push_pc           = '0;
    bus.push_target       = '0;
    bus.push_hit          = 1'b0;
    bus.push_pred         = 1'b0;
    bus.resolve_valid     = 1'b0;
    bus.resolve_is_branch = 1'b0;
    bus.resolve_is_jump   = 1'b0;
    bus.resolve_taken     = 1'b0;
    bus.resolve_target    = '0;
  endtask

  task automatic push(logic [DW-1:0] pc, logic [DW-1:0] tgt, logic hit, logic pred);
    bus.push_valid  = 1'b1;
    bus.push_pc     = pc;
    bus.push_target = tgt;
    bus.push_hit    = hit;
    bus.push_pred   = pred;
  endtask

  task automatic resolve(logic br, logic jmp, logic taken, logic [DW-1:0] tgt);
    bus.resolve_valid     = 1'b1;
    bus.resolve_is_branch = br;
    bus.resolve_is_jump   = jmp;
    bus.resolve_taken     = taken;
    bus.resolve_target    = tgt;
  endtask

  task automatic check_outputs(exp_t e);
    chk("update_predictor", bus.update_predictor, e.up);
    chk("update_btb", bus.update_btb, e.ub);
    chk("actually_taken", bus.actually_taken, e.at);
    chk("resolved_pc", bus.resolved_pc, e.rpc);
    chk("resolved_pc_target", bus.resolved_pc_target, e.rtgt);
    chk("flush", bus.flush, e.fl);
    chk("redirect_pc", bus.redirect_pc, e.rd);
    chk("underflow_err", bus.underflow_err, e.uf);
`ifdef BR_RESOLVE_STATS_EN
    chk("branch_count", branch_count, e.bc);
    chk("mispredict_count", mispredict_count, e.mc);
`endif
  endtask

  function automatic exp_t snapshot(logic up, logic ub, logic fl);
    exp_t e;
    e.up = up; e.ub = ub; e.fl = fl;
    e.at = m_at; e.rpc = m_rpc; e.rtgt = m_rtgt; e.rd = m_rd; e.uf = m_uf;
    e.bc = m_bc; e.mc = m_mc;
    return e;
  endfunction

  // One clock: model the cycle from the driven inputs, then check after the edge.
  task automatic step();
    exp_t e;
    rec_t h;
    rec_t r;
    logic run, pr, acc, uf, brj, eff, mis, up, ub;
    #1;
    run = (m_state == 1'b0);
    pr  = run && ((mq.size() < DEPTH) || bus.resolve_valid);
    chk("push_ready", bus.push_ready, pr);
    acc = run && bus.resolve_valid && (mq.size() != 0);
    uf  = run && bus.resolve_valid && (mq.size() == 0);
    mis = 1'b0; up = 1'b0; ub = 1'b0;
    if (acc) begin
      h   = mq.pop_front();
      brj = bus.resolve_is_branch | bus.resolve_is_jump;
      eff = h.hit & h.pred;
      mis = brj && ((bus.resolve_taken != eff) ||
                    (bus.resolve_taken && eff && (bus.resolve_target != h.tgt)));
      up  = bus.resolve_is_branch;
      ub  = bus.resolve_taken & brj;
      if (brj) begin
        m_at = bus.resolve_taken; m_rpc = h.pc; m_rtgt = bus.resolve_target;
        m_bc = m_bc + 32'd1;
      end
      if (mis) begin
        m_rd = bus.resolve_taken ? bus.resolve_target : h.pc + 32'd4;
        m_mc = m_mc + 32'd1;
        mq.delete();
      end
    end
    if (bus.push_valid && pr && !mis) begin
      r.pc = bus.push_pc; r.tgt = bus.push_target; r.hit = bus.push_hit; r.pred = bus.push_pred;
      mq.push_back(r);
    end
    if (uf) m_uf = 1'b1;
    m_state = mis;
    sb.push_back(snapshot(up, ub, mis));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check_outputs(e);
    end
    idle();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #2;
    mq.delete(); sb.delete();
    m_state = 1'b0; m_at = 1'b0; m_rpc = '0; m_rtgt = '0; m_rd = '0; m_uf = 1'b0;
    m_bc = '0; m_mc = '0;
    check_outputs(snapshot(1'b0, 1'b0, 1'b0));
    chk("push_ready_in_reset", bus.push_ready, 1'b1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rstn = 1'b0;
    idle();
    do_reset();

    // Correct taken prediction: updates but no flush
    push(32'h100, 32'h200, 1'b1, 1'b1); step();
    resolve(1'b1, 1'b0, 1'b1, 32'h200); step();
    step();

    // BTB miss, actually taken: flush to target, one RECOVER cycle refuses a push
    push(32'h100, 32'h0, 1'b0, 1'b0); step();
    resolve(1'b1, 1'b0, 1'b1, 32'h180); step();
    push(32'h900, 32'h0, 1'b0, 1'b0); resolve(1'b1, 1'b0, 1'b0, 32'h0); step();
    step();

    // Predicted taken, actually not taken: redirect to pc+4
    push(32'h100, 32'h200, 1'b1, 1'b1); step();
    resolve(1'b1, 1'b0, 1'b0, 32'h0); step();
    step();

    // Jump correct, then jump with wrong target
    push(32'h300, 32'h400, 1'b1, 1'b1); step();
    resolve(1'b0, 1'b1, 1'b1, 32'h400); step();
    push(32'h300, 32'h400, 1'b1, 1'b1); step();
    resolve(1'b0, 1'b1, 1'b1, 32'h440); step();
    step();

    // Non-branch resolve pops silently
    push(32'h500, 32'h0, 1'b0, 1'b0); step();
    resolve(1'b0, 1'b0, 1'b1, 32'h77); step();

    // Fill, full back-pressure, push+pop when full, then flush with records queued
    for (int i = 0; i < DEPTH; i++) begin
      push(32'h1000 + 32'(i * 4), 32'h2000, 1'b1, 1'b0); step();
    end
    push(32'h1100, 32'h2000, 1'b1, 1'b0); step();
    push(32'h1010, 32'h2000, 1'b1, 1'b0); resolve(1'b1, 1'b0, 1'b0, 32'h0); step();
    push(32'h1014, 32'h2000, 1'b1, 1'b0); step();
    resolve(1'b1, 1'b0, 1'b0, 32'h0); step();
    push(32'h1018, 32'h0, 1'b0, 1'b0); resolve(1'b1, 1'b0, 1'b1, 32'h3000); step();
    resolve(1'b1, 1'b0, 1'b0, 32'h0); step();
    step();

    // FIFO must be empty now: this resolve underflows, and the flag sticks
    resolve(1'b1, 1'b0, 1'b1, 32'h40); step();
    step();
    step();
    do_reset();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0)
        push(32'h4000 + 32'(i * 4), ($urandom_range(0, 1) != 0) ? 32'h8000 : 32'h8040,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0)
        resolve(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) != 0) ? 32'h8000 : 32'h8040);
      step();
    end

    // Reset while records are queued, then confirm they are gone
    for (int i = 0; i < 3; i++) begin
      push(32'h6000 + 32'(i * 4), 32'h0, 1'b0, 1'b0); step();
    end
    do_reset();
    step();
    resolve(1'b1, 1'b0, 1'b1, 32'h10); step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
